mmu_act_skew: RTL and testbench



---
 rtl/mmu_pkg.sv | 6 +
 rtl/mmu_act_skew_if.sv | 27 ++
 rtl/mmu_act_fifo.sv | 44 ++++
 rtl/mmu_act_skew.sv | 123 ++++++++++++
 tb/tb_mmu_act_skew.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU feeder types and the default array geometry used by the PE array.
package mmu_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
   localparam int MMU_ROWS = 8;
   localparam int MMU_DATA_WIDTH = 16;
endpackage

// File: rtl/mmu_act_skew_if.sv
// mmu_act_skew_if: activation input stream, skewed per-row outputs and pass status of the feeder.
interface mmu_act_skew_if
   import mmu_pkg::*;
#(
   parameter int ROWS = MMU_ROWS,
   parameter int DATA_WIDTH = MMU_DATA_WIDTH,
   parameter int CNT_WIDTH = 16
);
   logic start;
   logic in_valid;
   logic in_ready;
   logic [ROWS*DATA_WIDTH-1:0] in_data;
   logic in_last;
   logic [ROWS-1:0] act_en_out;
   logic [ROWS*DATA_WIDTH-1:0] act_out;
   logic busy;
   logic done;
   logic [CNT_WIDTH-1:0] vec_count;
   modport master (
      output start, in_valid, in_data, in_last,
      input in_ready, act_en_out, act_out, busy, done, vec_count
   );
   modport slave (
      input start, in_valid, in_data, in_last,
      output in_ready, act_en_out, act_out, busy, done, vec_count
   );
endinterface

// File: rtl/mmu_act_fifo.sv
// mmu_act_fifo: synchronous FIFO; a push while full is refused even if a pop happens that cycle.
module mmu_act_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign rdata = mem_q[rp_q];
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wp_q] = wdata;
      wp_d = do_push ? wp_q + AW'(1) : wp_q;
      rp_d = do_pop ? rp_q + AW'(1) : rp_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
      end
endmodule

// File: rtl/mmu_act_skew.sv
// mmu_act_skew: buffers activation vectors and feeds them into the MMU with row r delayed r cycles.
// Define MMU_ACT_SKEW_PERF_EN to add the bubble_count port counting empty RUN cycles.
module mmu_act_skew
   import mmu_pkg::*;
#(
   parameter int ROWS = MMU_ROWS,
   parameter int DATA_WIDTH = MMU_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH = 16
) (
   input logic clk,
   input logic rstn,
`ifdef MMU_ACT_SKEW_PERF_EN
   mmu_act_skew_if.slave io,
   output logic [CNT_WIDTH-1:0] bubble_count
`else
   mmu_act_skew_if.slave io
`endif
);
   localparam int W = ROWS*DATA_WIDTH;
   state_e state_q, state_d;
   logic [CNT_WIDTH-1:0] vec_count_q, vec_count_d;
   logic full, empty, pop, pass_start, fifo_last;
   logic [W-1:0] fifo_data;
   logic s0_en_q, s0_en_d, s0_last_q, s0_last_d;
   logic [W-1:0] s0_data_q, s0_data_d;
   logic [ROWS-1:0] row_en;
   logic [W-1:0] row_data;
   logic row_last;
   mmu_act_fifo #(.WIDTH(W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rstn(rstn),
      .push(io.in_valid),
      .pop(pop),
      .wdata({io.in_last, io.in_data}),
      .rdata({fifo_last, fifo_data}),
      .full(full),
      .empty(empty)
   );
   assign pass_start = state_q == IDLE && io.start;
   assign pop = state_q == RUN && !empty;
   always_comb begin
      state_d = pass_start ? RUN
              : (pop && fifo_last) ? DRAIN
              : (state_q == DRAIN && io.done) ? IDLE : state_q;
      vec_count_d = pass_start ? '0
                  : (pop && vec_count_q != '1) ? vec_count_q + CNT_WIDTH'(1) : vec_count_q;
      s0_en_d = pop;
      s0_data_d = pop ? fifo_data : '0;
      s0_last_d = pop && fifo_last;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q <= IDLE;
         vec_count_q <= '0;
         s0_en_q <= 1'b0;
         s0_data_q <= '0;
         s0_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_count_q <= vec_count_d;
         s0_en_q <= s0_en_d;
         s0_data_q <= s0_data_d;
         s0_last_q <= s0_last_d;
      end
   assign row_en[0] = s0_en_q;
   assign row_data[DATA_WIDTH-1:0] = s0_data_q[DATA_WIDTH-1:0];
   // Row r keeps only its own element slice through r extra stages; bubbles shift like data.
   for (genvar r = 1; r < ROWS; r++) begin : g_row
      logic [r-1:0] en_q, en_d;
      logic [DATA_WIDTH-1:0] dat_q [r];
      logic [DATA_WIDTH-1:0] dat_d [r];
      always_comb begin
         en_d[0] = s0_en_q;
         dat_d[0] = s0_data_q[r*DATA_WIDTH +: DATA_WIDTH];
         for (int k = 1; k < r; k++) begin
            en_d[k] = en_q[k-1];
            dat_d[k] = dat_q[k-1];
         end
      end
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            en_q <= '0;
            dat_q <= '{default: '0};
         end else begin
            en_q <= en_d;
            dat_q <= dat_d;
         end
      assign row_en[r] = en_q[r-1];
      assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r-1];
      if (r == ROWS-1) begin : g_last
         logic [r-1:0] last_q, last_d;
         always_comb begin
            last_d[0] = s0_last_q;
            for (int k = 1; k < r; k++) last_d[k] = last_q[k-1];
         end
         always_ff @(posedge clk or negedge rstn)
            if (!rstn) last_q <= '0;
            else last_q <= last_d;
         assign row_last = last_q[r-1];
      end
   end
   if (ROWS == 1) begin : g_one
      assign row_last = s0_last_q;
   end
   assign io.in_ready = !full;
   assign io.act_en_out = row_en;
   assign io.act_out = row_data;
   assign io.busy = state_q != IDLE;
   assign io.done = row_en[ROWS-1] && row_last;
   assign io.vec_count = vec_count_q;
`ifdef MMU_ACT_SKEW_PERF_EN
   logic [CNT_WIDTH-1:0] bubble_count_q, bubble_count_d;
   always_comb
      bubble_count_d = pass_start ? '0
                     : (state_q == RUN && empty && bubble_count_q != '1) ? bubble_count_q + CNT_WIDTH'(1)
                     : bubble_count_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) bubble_count_q <= '0;
      else bubble_count_q <= bubble_count_d;
   assign bubble_count = bubble_count_q;
`endif
endmodule

// File: tb/tb_mmu_act_skew.sv
// tb_mmu_act_skew: scoreboarded random and directed checks of the skewed activation feeder.
module tb_mmu_act_skew;
   localparam int R = 4;
   localparam int DW = 8;
   localparam int D = 4;
   localparam int CW = 16;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mmu_act_skew_if #(.ROWS(R), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) io ();
   mmu_act_skew_if #(.ROWS(1), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) io1 ();
`ifdef MMU_ACT_SKEW_PERF_EN
   logic [CW-1:0] bub, bub1;
   mmu_act_skew #(.ROWS(R), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn), .io(io), .bubble_count(bub));
   mmu_act_skew #(.ROWS(1), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut1 (
      .clk(clk), .rstn(rstn), .io(io1), .bubble_count(bub1));
`else
   mmu_act_skew #(.ROWS(R), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn), .io(io));
   mmu_act_skew #(.ROWS(1), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut1 (
      .clk(clk), .rstn(rstn), .io(io1));
`endif
   // scoreboard: per-row expected elements in issue order, last tags for row R-1
   logic [DW-1:0] exp_q [R][$];
   bit exp_last_q[$];
   int t0[$];
   int nseen [R];
   int seen_t [R][$];
   logic [DW-1:0] exp1_q[$];
   int t1 = -1;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void flush();
      for (int r = 0; r < R; r++) begin
         exp_q[r].delete();
         seen_t[r].delete();
         nseen[r] = 0;
      end
      exp_last_q.delete();
      t0.delete();
   endfunction

   function automatic void clear_seen();
      for (int r = 0; r < R; r++) seen_t[r].delete();
   endfunction

   always @(negedge clk) if (rstn) begin
      for (int r = 0; r < R; r++) if (io.act_en_out[r]) begin
         if (exp_q[r].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL row%0d unexpected output: got %0h expected none", r, io.act_out[r*DW +: DW]);
         end else begin
            chk($sformatf("row%0d data", r), 64'(io.act_out[r*DW +: DW]), 64'(exp_q[r].pop_front()));
            if (r == 0) t0.push_back(cyc);
            else chk($sformatf("row%0d skew", r), 64'(cyc), 64'(t0[nseen[r]] + r));
            nseen[r]++;
            seen_t[r].push_back(cyc);
            if (r == R-1) chk("done on last row", 64'(io.done), 64'(exp_last_q.pop_front()));
         end
      end
      if (!io.act_en_out[R-1]) chk("done idle", 64'(io.done), 64'(0));
   end

   always @(negedge clk) if (rstn) begin
      if (io1.act_en_out[0]) begin
         if (exp1_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL r1 unexpected output: got %0h expected none", io1.act_out);
         end else begin
            chk("r1 data", 64'(io1.act_out), 64'(exp1_q.pop_front()));
            chk("r1 done", 64'(io1.done), 64'(1));
            t1 = cyc;
         end
      end else chk("r1 done idle", 64'(io1.done), 64'(0));
   end

   function automatic logic [R*DW-1:0] seqvec(int base);
      logic [R*DW-1:0] v;
      for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'(base + r);
      return v;
   endfunction

   task automatic push_vec(input logic [R*DW-1:0] d, input bit last, output bit acc);
      io.in_valid = 1'b1;
      io.in_data = d;
      io.in_last = last;
      acc = io.in_ready;
      @(negedge clk);
      io.in_valid = 1'b0;
      if (acc) begin
         for (int r = 0; r < R; r++) exp_q[r].push_back(d[r*DW +: DW]);
         exp_last_q.push_back(last);
      end
   endtask

   task automatic push_retry(input logic [R*DW-1:0] d, input bit last);
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 40) begin
         push_vec(d, last, acc);
         tries++;
      end
      chk("push accepted eventually", 64'(acc), 64'(1));
   endtask

   task automatic start_pass(output int s);
      io.start = 1'b1;
      s = cyc;
      @(negedge clk);
      io.start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int dc);
      dc = -1;
      for (int i = 0; i < maxc; i++) begin
         if (io.done) begin
            dc = cyc;
            break;
         end
         @(negedge clk);
      end
      tests++;
      if (dc < 0) begin
         fails++;
         $display("FAIL done timeout: got no done expected within %0d cycles", maxc);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got no finish expected before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      int s, dc, n, pre;
      bit acc;
      logic [R*DW-1:0] v;
      io.start = 0; io.in_valid = 0; io.in_data = '0; io.in_last = 0;
      io1.start = 0; io1.in_valid = 0; io1.in_data = '0; io1.in_last = 0;
      flush();
      repeat (2) @(negedge clk);
      chk("rst act_en_out", 64'(io.act_en_out), 64'(0));
      chk("rst act_out", 64'(io.act_out), 64'(0));
      chk("rst busy", 64'(io.busy), 64'(0));
      chk("rst done", 64'(io.done), 64'(0));
      chk("rst vec_count", 64'(io.vec_count), 64'(0));
      chk("rst in_ready", 64'(io.in_ready), 64'(1));
      chk("rst r1 in_ready", 64'(io1.in_ready), 64'(1));
`ifdef MMU_ACT_SKEW_PERF_EN
      chk("rst bubble_count", 64'(bub), 64'(0));
`endif
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      // three preloaded vectors 1..12
      for (int k = 0; k < 3; k++) begin
         push_vec(seqvec(4*k + 1), k == 2, acc);
         chk("preload accepted", 64'(acc), 64'(1));
      end
      clear_seen();
      start_pass(s);
      chk("busy after start", 64'(io.busy), 64'(1));
      wait_done(50, dc);
      chk("t1 done cycle", 64'(dc), 64'(s + 7));
      for (int k = 0; k < 3; k++) begin
         chk("t1 row0 time", 64'(k < seen_t[0].size() ? seen_t[0][k] : -1), 64'(s + 2 + k));
         chk("t1 row3 time", 64'(k < seen_t[3].size() ? seen_t[3][k] : -1), 64'(s + 5 + k));
      end
      chk("t1 vec_count", 64'(io.vec_count), 64'(3));
      chk("t1 busy after done", 64'(io.busy), 64'(0));
`ifdef MMU_ACT_SKEW_PERF_EN
      chk("t1 bubble_count", 64'(bub), 64'(0));
`endif
      // gap: A popped, two empty RUN cycles, then B(last)
      repeat (2) @(negedge clk);
      push_vec(seqvec(100), 1'b0, acc);
      clear_seen();
      start_pass(s);
      repeat (2) @(negedge clk);
      push_vec(seqvec(200), 1'b1, acc);
      wait_done(50, dc);
      for (int r = 0; r < R; r++)
         chk($sformatf("gap row%0d spacing", r),
             64'(seen_t[r].size() == 2 ? seen_t[r][1] - seen_t[r][0] : -1), 64'(3));
      chk("gap vec_count", 64'(io.vec_count), 64'(2));
`ifdef MMU_ACT_SKEW_PERF_EN
      chk("gap bubble_count", 64'(bub), 64'(2));
`endif
      // full FIFO while idle
      repeat (2) @(negedge clk);
      for (int k = 0; k < D; k++) begin
         push_vec(seqvec(20 + 4*k), k == D-1, acc);
         chk("fill accepted", 64'(acc), 64'(1));
      end
      chk("full in_ready", 64'(io.in_ready), 64'(0));
      push_vec(seqvec(90), 1'b0, acc);
      chk("push while full refused", 64'(acc), 64'(0));
      start_pass(s);
      chk("in_ready at first pop", 64'(io.in_ready), 64'(0));
      @(negedge clk);
      chk("in_ready after first pop", 64'(io.in_ready), 64'(1));
      wait_done(50, dc);
      chk("full vec_count", 64'(io.vec_count), 64'(D));
      // start in RUN and in DRAIN is ignored
      repeat (2) @(negedge clk);
      push_vec(seqvec(40), 1'b0, acc);
      push_vec(seqvec(44), 1'b1, acc);
      start_pass(s);
      @(negedge clk);
      io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      @(negedge clk);
      io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      chk("vec_count in drain", 64'(io.vec_count), 64'(2));
      wait_done(50, dc);
      chk("ignored start done cycle", 64'(dc), 64'(s + 6));
      chk("ignored start vec_count", 64'(io.vec_count), 64'(2));
      chk("ignored start idle", 64'(io.busy), 64'(0));
      // reset in DRAIN while the last vector sits on row 1
      repeat (2) @(negedge clk);
      push_vec(seqvec(60), 1'b1, acc);
      start_pass(s);
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset row1 en", 64'(io.act_en_out), 64'(4'b0010));
      #2 rstn = 1'b0;
      flush();
      #1;
      chk("abort act_en_out", 64'(io.act_en_out), 64'(0));
      chk("abort busy", 64'(io.busy), 64'(0));
      chk("abort done", 64'(io.done), 64'(0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      // single-row feeder
      io1.in_valid = 1'b1;
      io1.in_data = 8'h5a;
      io1.in_last = 1'b1;
      exp1_q.push_back(8'h5a);
      @(negedge clk);
      io1.in_valid = 1'b0;
      io1.start = 1'b1;
      s = cyc;
      @(negedge clk);
      io1.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("r1 output cycle", 64'(t1), 64'(s + 2));
      chk("r1 vec_count", 64'(io1.vec_count), 64'(1));
      chk("r1 idle after done", 64'(io1.busy), 64'(0));
      // randomized passes
      for (int p = 0; p < 10; p++) begin
         n = $urandom_range(1, 7);
         pre = $urandom_range(0, n < D ? n : D);
         for (int k = 0; k < pre; k++) begin
            v = $urandom();
            push_retry(v, k == n-1);
         end
         start_pass(s);
         for (int k = pre; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            v = $urandom();
            push_retry(v, k == n-1);
         end
         wait_done(200, dc);
         chk("rand vec_count", 64'(io.vec_count), 64'(n));
         for (int r = 0; r < R; r++)
            chk($sformatf("rand row%0d drained", r), 64'(exp_q[r].size()), 64'(0));
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
